// File: rtl/maxpool_engine.sv
// 2x2 stride-2 max/average pooling engine over a multi-channel BRAM image.
// Results are packed PACK per word and sent on a valid/ready write port.
module maxpool_engine #(
  parameter int DATA_W   = 16,
  parameter int IMG_W    = 40,
  parameter int IMG_H    = 40,
  parameter int CHANNELS = 4,
  parameter int PACK     = 4,
  parameter int RD_LAT   = 1,
  parameter int ADDR_W   = 16,
  parameter int SIGNED   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mode,
  output logic [ADDR_W-1:0]      rd_addr,
  output logic                   rd_en,
  input  logic [DATA_W-1:0]      rd_data,
  output logic [DATA_W*PACK-1:0] out_data,
  output logic [ADDR_W-1:0]      out_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   ch_done,
  output logic [7:0]             ch_idx,
  output logic                   all_done
);

  localparam int WO    = IMG_W / 2;
  localparam int HO    = IMG_H / 2;
  localparam int XW    = $clog2(WO + 1);
  localparam int YW    = $clog2(HO + 1);
  localparam int SW    = $clog2(PACK + 1);
  localparam int PW    = DATA_W * PACK;
  localparam int PLANE = IMG_W * IMG_H;

  if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0) begin : g_geom_chk
    $error("maxpool_engine: IMG_W and IMG_H must be even");
  end

  typedef enum logic [2:0] {
    IDLE, RD, WAIT, RED, EMIT
  } state_t;

  state_t state_q, state_d;

  logic              mode_q;
  logic [7:0]        ch_q;
  logic [ADDR_W-1:0] ch_base_q;
  logic [XW-1:0]     wx_q;
  logic [YW-1:0]     wy_q;
  logic [SW-1:0]     slot_q;
  logic [1:0]        q_q;
  logic [1:0]        wcnt_q;
  logic [1:0]        cap_q;
  logic [RD_LAT-1:0] dly_q;
  logic [DATA_W-1:0] smp_q [4];
  logic [PW-1:0]     pack_q;
  logic [ADDR_W-1:0] oaddr_q;
  logic              ch_end_q;
  logic              busy_q;
  logic              ch_done_q;
  logic              all_done_q;

  logic              last_win;
  logic              last_ch;
  logic              emit_now;
  logic [YW:0]       row;
  logic [XW:0]       col;
  logic [ADDR_W-1:0] rd_addr_c;
  logic [DATA_W-1:0] mx;
  logic [DATA_W+1:0] sum;
  logic [DATA_W-1:0] red;

  function automatic logic gt(input logic [DATA_W-1:0] a,
                              input logic [DATA_W-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    else return a > b;
  endfunction

  function automatic logic [DATA_W+1:0] ext(input logic [DATA_W-1:0] x);
    if (SIGNED != 0) return {{2{x[DATA_W-1]}}, x};
    else return {2'b00, x};
  endfunction

  assign last_win = (wx_q == XW'(WO - 1)) && (wy_q == YW'(HO - 1));
  assign last_ch  = (ch_q == 8'(CHANNELS - 1));
  assign emit_now = (slot_q == SW'(PACK - 1)) || last_win;

  assign row       = {wy_q, q_q[1]};
  assign col       = {wx_q, q_q[0]};
  assign rd_addr_c = ch_base_q
                   + ADDR_W'(row) * ADDR_W'(IMG_W)
                   + ADDR_W'(col);

  // Strict greater-than keeps the earlier sample on ties.
  always_comb begin
    mx = smp_q[0];
    for (int i = 1; i < 4; i++) begin
      if (gt(smp_q[i], mx)) mx = smp_q[i];
    end
  end

  assign sum = ext(smp_q[0]) + ext(smp_q[1])
             + ext(smp_q[2]) + ext(smp_q[3]);
  assign red = mode_q ? DATA_W'(sum >> 2) : mx;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RD;
      RD:   if (q_q == 2'd3) state_d = WAIT;
      WAIT: if (wcnt_q == 2'(RD_LAT - 1)) state_d = RED;
      RED:  state_d = emit_now ? EMIT : RD;
      EMIT: begin
        if (out_ready) begin
          state_d = (ch_end_q && last_ch) ? IDLE : RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= 1'b0;
      ch_q       <= '0;
      ch_base_q  <= '0;
      wx_q       <= '0;
      wy_q       <= '0;
      slot_q     <= '0;
      q_q        <= '0;
      wcnt_q     <= '0;
      cap_q      <= '0;
      dly_q      <= '0;
      smp_q      <= '{default: '0};
      pack_q     <= '0;
      oaddr_q    <= '0;
      ch_end_q   <= 1'b0;
      busy_q     <= 1'b0;
      ch_done_q  <= 1'b0;
      all_done_q <= 1'b0;
    end else begin
      ch_done_q  <= 1'b0;
      all_done_q <= 1'b0;
      // Capture follows the read-strobe delay line, not the FSM state.
      dly_q <= RD_LAT'({dly_q, rd_en});
      if (dly_q[RD_LAT-1]) begin
        smp_q[cap_q] <= rd_data;
        cap_q        <= cap_q + 2'd1;
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            mode_q    <= mode;
            busy_q    <= 1'b1;
            ch_q      <= '0;
            ch_base_q <= '0;
            wx_q      <= '0;
            wy_q      <= '0;
            slot_q    <= '0;
            q_q       <= '0;
            cap_q     <= '0;
            pack_q    <= '0;
            oaddr_q   <= '0;
            ch_end_q  <= 1'b0;
          end
        end
        RD: begin
          q_q    <= q_q + 2'd1;
          wcnt_q <= '0;
        end
        WAIT: wcnt_q <= wcnt_q + 2'd1;
        RED: begin
          pack_q[int'(slot_q)*DATA_W +: DATA_W] <= red;
          slot_q   <= emit_now ? '0 : slot_q + SW'(1);
          ch_end_q <= last_win;
          if (last_win) begin
            wx_q <= '0;
            wy_q <= '0;
          end else if (wx_q == XW'(WO - 1)) begin
            wx_q <= '0;
            wy_q <= wy_q + YW'(1);
          end else begin
            wx_q <= wx_q + XW'(1);
          end
        end
        EMIT: begin
          if (out_ready) begin
            pack_q  <= '0;
            oaddr_q <= oaddr_q + ADDR_W'(1);
            if (ch_end_q) begin
              ch_done_q <= 1'b1;
              ch_end_q  <= 1'b0;
              if (last_ch) begin
                all_done_q <= 1'b1;
                busy_q     <= 1'b0;
              end else begin
                ch_q      <= ch_q + 8'd1;
                ch_base_q <= ch_base_q + ADDR_W'(PLANE);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_en     = (state_q == RD);
  assign rd_addr   = rd_en ? rd_addr_c : '0;
  assign out_valid = (state_q == EMIT);
  assign out_data  = out_valid ? pack_q : '0;
  assign out_addr  = oaddr_q;
  assign busy      = busy_q;
  assign ch_done   = ch_done_q;
  assign ch_idx    = ch_q;
  assign all_done  = all_done_q;

endmodule

// File: tb/tb_maxpool_engine.sv
// Scoreboard bench for maxpool_engine: 4x4x2 image at RD_LAT=1 and a
// signed 6x2x1 image at RD_LAT=2 with a partial final word.
module tb_maxpool_engine;

  typedef struct packed {
    logic [63:0] d;
    logic [15:0] a;
  } exp_t;

  localparam logic [63:0] A_MAX0 = {16'd15, 16'd13, 16'd7, 16'd5};
  localparam logic [63:0] A_MAX1 = {16'd31, 16'd29, 16'd23, 16'd21};
  localparam logic [63:0] A_AVG0 = {16'd12, 16'd10, 16'd4, 16'd2};
  localparam logic [63:0] A_AVG1 = {16'd28, 16'd26, 16'd20, 16'd18};
  localparam logic [63:0] B_MAX  = {16'h0, 16'd11, 16'd9, 16'hFFFF};
  localparam logic [63:0] B_AVG  = {16'h0, 16'd7, 16'd5, 16'hFFFC};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mode, start_a, start_b, rdy_a, rdy_b;
  logic [15:0] rd_addr_a, rd_data_a, out_addr_a;
  logic [15:0] rd_addr_b, rd_data_b, out_addr_b;
  logic        rd_en_a, out_valid_a, busy_a, ch_done_a, all_done_a;
  logic        rd_en_b, out_valid_b, busy_b, ch_done_b, all_done_b;
  logic [63:0] out_data_a, out_data_b;
  logic [7:0]  ch_idx_a, ch_idx_b;

  logic [15:0] mem_a [32];
  logic [15:0] mem_b [16];
  logic [15:0] pa, pb1, pb2;

  int   checks = 0;
  int   errors = 0;
  int   chd_a = 0, alld_a = 0, chd_b = 0, alld_b = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb, hd_a, hd_b;
  bit   hold_a = 0, hold_b = 0;

  maxpool_engine #(
    .DATA_W(16), .IMG_W(4), .IMG_H(4), .CHANNELS(2),
    .PACK(4), .RD_LAT(1), .ADDR_W(16), .SIGNED(1)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode),
    .rd_addr(rd_addr_a), .rd_en(rd_en_a), .rd_data(rd_data_a),
    .out_data(out_data_a), .out_addr(out_addr_a),
    .out_valid(out_valid_a), .out_ready(rdy_a),
    .busy(busy_a), .ch_done(ch_done_a), .ch_idx(ch_idx_a),
    .all_done(all_done_a)
  );

  maxpool_engine #(
    .DATA_W(16), .IMG_W(6), .IMG_H(2), .CHANNELS(1),
    .PACK(4), .RD_LAT(2), .ADDR_W(16), .SIGNED(1)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode),
    .rd_addr(rd_addr_b), .rd_en(rd_en_b), .rd_data(rd_data_b),
    .out_data(out_data_b), .out_addr(out_addr_b),
    .out_valid(out_valid_b), .out_ready(rdy_b),
    .busy(busy_b), .ch_done(ch_done_b), .ch_idx(ch_idx_b),
    .all_done(all_done_b)
  );

  always @(posedge clk) begin
    pa  <= mem_a[rd_addr_a[4:0]];
    pb1 <= mem_b[rd_addr_b[3:0]];
    pb2 <= pb1;
  end
  assign rd_data_a = pa;
  assign rd_data_b = pb2;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid_a) begin
        chk("a_rd_en_in_emit", rd_en_a, 0);
        if (hold_a) begin
          chk("a_hold_data", out_data_a, hd_a.d);
          chk("a_hold_addr", out_addr_a, hd_a.a);
        end
        if (rdy_a) begin
          hold_a = 0;
          if (qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_unexpected_word actual=%h", out_data_a);
          end else begin
            ea = qa.pop_front();
            chk("a_data", out_data_a, ea.d);
            chk("a_addr", out_addr_a, ea.a);
          end
        end else begin
          hold_a = 1;
          hd_a.d = out_data_a;
          hd_a.a = out_addr_a;
        end
      end else hold_a = 0;
      if (all_done_a) begin
        alld_a++;
        chk("a_alldone_w_chdone", {ch_done_a, busy_a}, 2'b10);
      end
      if (ch_done_a) chd_a++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid_b) begin
        chk("b_rd_en_in_emit", rd_en_b, 0);
        if (hold_b) begin
          chk("b_hold_data", out_data_b, hd_b.d);
          chk("b_hold_addr", out_addr_b, hd_b.a);
        end
        if (rdy_b) begin
          hold_b = 0;
          if (qb.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected_word actual=%h", out_data_b);
          end else begin
            eb = qb.pop_front();
            chk("b_data", out_data_b, eb.d);
            chk("b_addr", out_addr_b, eb.a);
          end
        end else begin
          hold_b = 1;
          hd_b.d = out_data_b;
          hd_b.a = out_addr_b;
        end
      end else hold_b = 0;
      if (all_done_b) begin
        alld_b++;
        chk("b_alldone_w_chdone", {ch_done_b, busy_b}, 2'b10);
      end
      if (ch_done_b) chd_b++;
    end
  end

  task automatic chk_rst_a();
    chk("a_rst_data", out_data_a, 0);
    chk("a_rst_ctl", {rd_addr_a, out_addr_a, ch_idx_a, rd_en_a,
        out_valid_a, busy_a, ch_done_a, all_done_a}, 0);
  endtask

  task automatic chk_rst_b();
    chk("b_rst_data", out_data_b, 0);
    chk("b_rst_ctl", {rd_addr_b, out_addr_b, ch_idx_b, rd_en_b,
        out_valid_b, busy_b, ch_done_b, all_done_b}, 0);
  endtask

  task automatic wait_done(input bit which, input int a0);
    int n = 0;
    while (((which ? alld_b : alld_a) == a0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL %s_timeout all_done not seen", which ? "b" : "a");
    end
  endtask

  task automatic run_a(input logic m, input logic [63:0] w0,
                       input logic [63:0] w1, input int stall,
                       input int repulse);
    int c0, a0, n;
    c0 = chd_a;
    a0 = alld_a;
    qa.push_back('{w0, 16'd0});
    qa.push_back('{w1, 16'd1});
    @(posedge clk); #1;
    mode = m;
    start_a = 1;
    if (stall > 0) rdy_a = 0;
    @(posedge clk); #1;
    start_a = 0;
    if (repulse > 0) begin
      repeat (repulse) @(posedge clk);
      #1;
      mode = ~m;
      start_a = 1;
      @(posedge clk); #1;
      start_a = 0;
    end
    if (stall > 0) begin
      n = 0;
      while (!out_valid_a && n < 500) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 500) begin
        checks++; errors++;
        $display("FAIL a_valid_timeout out_valid not seen");
      end
      repeat (stall) @(posedge clk);
      #1;
      rdy_a = 1;
    end
    wait_done(0, a0);
    chk("a_chdone_count", chd_a - c0, 2);
    chk("a_alldone_count", alld_a - a0, 1);
    chk("a_ch_idx_end", ch_idx_a, 1);
    chk("a_queue_left", qa.size(), 0);
    chk("a_busy_end", busy_a, 0);
  endtask

  task automatic run_b(input logic m, input logic [63:0] w);
    int c0, a0;
    c0 = chd_b;
    a0 = alld_b;
    qb.push_back('{w, 16'd0});
    @(posedge clk); #1;
    mode = m;
    start_b = 1;
    @(posedge clk); #1;
    start_b = 0;
    wait_done(1, a0);
    chk("b_chdone_count", chd_b - c0, 1);
    chk("b_alldone_count", alld_b - a0, 1);
    chk("b_ch_idx_end", ch_idx_b, 0);
    chk("b_queue_left", qb.size(), 0);
  endtask

  initial begin
    int a0, c0, n;
    rst = 1; mode = 0; start_a = 0; start_b = 0;
    rdy_a = 1; rdy_b = 1;
    for (int i = 0; i < 32; i++) mem_a[i] = 16'(i);
    for (int i = 0; i < 16; i++) mem_b[i] = 16'(i);
    mem_b[0] = 16'hFFFD;
    mem_b[1] = 16'hFFFF;
    mem_b[6] = 16'hFFF8;
    mem_b[7] = 16'hFFFE;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst_a();
    chk_rst_b();
    @(posedge clk); #1;
    rst = 0;

    run_a(0, A_MAX0, A_MAX1, 0, 0);
    run_a(1, A_AVG0, A_AVG1, 0, 0);
    run_b(0, B_MAX);
    run_b(1, B_AVG);
    run_a(0, A_MAX0, A_MAX1, 10, 0);

    a0 = alld_a;
    c0 = chd_a;
    qa.push_back('{A_MAX0, 16'd0});
    qa.push_back('{A_MAX1, 16'd1});
    @(posedge clk); #1;
    mode = 0;
    start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    n = 0;
    while (ch_idx_a != 8'd1 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL a_ch1_timeout ch_idx never reached 1");
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk_rst_a();
    @(posedge clk); #1;
    rst = 0;
    qa.delete();
    repeat (30) @(posedge clk);
    #1;
    chk("a_abort_alldone", alld_a - a0, 0);
    chk("a_abort_chdone", chd_a - c0, 1);
    chk("a_abort_busy", busy_a, 0);
    run_a(0, A_MAX0, A_MAX1, 0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
